// File: rtl/registradores_param_if.sv
// Register-bank access bundle: decoder/control side drives addresses, strobes and
// write-back sources; the bank returns registered operands, debug data and busy.
interface registradores_param_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              en;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic [1:0]        wbsel;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   readdata1;
    logic [XLEN-1:0]   readdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_data;
    logic              busy;

    modport master (
        output en, rs1, rs2, rd, regwrite, wbsel,
        output alu_result, mem_data, pc_plus4, imm, dbg_addr,
        input  readdata1, readdata2, dbg_data, busy
    );

    modport slave (
        input  en, rs1, rs2, rd, regwrite, wbsel,
        input  alu_result, mem_data, pc_plus4, imm, dbg_addr,
        output readdata1, readdata2, dbg_data, busy
    );
endinterface

// File: rtl/registradores_param.sv
// Parametrised register bank with post-reset hardware clear, 4-way write-back select,
// hardwired x0 and registered debug port. Define REGFILE_BYPASS_EN for same-edge write->read bypass.
module registradores_param #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    registradores_param_if.slave bus
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] clr_ptr, next_ptr;
    logic [XLEN-1:0]   regs [NREGS];

    logic              run_we;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   wb_value;
    logic [XLEN-1:0]   rd1_value;
    logic [XLEN-1:0]   rd2_value;
    logic [XLEN-1:0]   dbg_value;

    always_comb begin
        wb_value = bus.alu_result;
        unique case (bus.wbsel)
            2'b00: wb_value = bus.alu_result;
            2'b01: wb_value = bus.mem_data;
            2'b10: wb_value = bus.pc_plus4;
            2'b11: wb_value = bus.imm;
        endcase
    end

    assign run_we = bus.en && bus.regwrite && (bus.rd != '0);

    // The clear sequencer owns the single write port while in CLEAR, which also
    // drops any write presented on a clock edge while rst is held.
    always_comb begin
        next_state = state;
        next_ptr   = clr_ptr;
        we         = 1'b0;
        waddr      = bus.rd;
        wdata      = wb_value;
        case (state)
            CLEAR: begin
                we       = 1'b1;
                waddr    = clr_ptr;
                wdata    = '0;
                next_ptr = clr_ptr + ADDR_W'(1);
                if (clr_ptr == ADDR_W'(NREGS - 1))
                    next_state = RUN;
            end
            RUN: begin
                we = run_we;
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= next_state;
            clr_ptr <= next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            regs[waddr] <= wdata;
    end

    always_comb begin
        rd1_value = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
        rd2_value = (bus.rs2 == '0) ? '0 : regs[bus.rs2];
        dbg_value = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];
`ifdef REGFILE_BYPASS_EN
        if (run_we && (bus.rd == bus.rs1))
            rd1_value = wb_value;
        if (run_we && (bus.rd == bus.rs2))
            rd2_value = wb_value;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.readdata1 <= '0;
            bus.readdata2 <= '0;
            bus.dbg_data  <= '0;
        end else if (state == CLEAR) begin
            bus.readdata1 <= '0;
            bus.readdata2 <= '0;
            bus.dbg_data  <= '0;
        end else begin
            bus.dbg_data <= dbg_value;
            if (bus.en) begin
                bus.readdata1 <= rd1_value;
                bus.readdata2 <= rd2_value;
            end
        end
    end

    assign bus.busy = (state == CLEAR);

endmodule

// File: tb/tb_registradores_param.sv
// Self-checking bench for registradores_param: directed tables, hazard/reset sequences
// and randomized traffic against an array-based reference model.
module tb_registradores_param;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    registradores_param_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    registradores_param #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic [1:0]        wbsel;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   mem;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [ADDR_W-1:0] dbg;
    } stim_t;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] rd;
        logic [1:0]        wbsel;
        logic [XLEN-1:0]   value;
        logic [XLEN-1:0]   expect_val;
    } wvec_t;

    logic [XLEN-1:0] model_regs [NREGS];
    int              clear_left;
    logic [XLEN-1:0] exp_rd1, exp_rd2, exp_dbg;
    int              checks   = 0;
    int              failures = 0;

    task automatic checkVal(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " readdata1"}, bus.readdata1, exp_rd1);
        checkVal({tag, " readdata2"}, bus.readdata2, exp_rd2);
        checkVal({tag, " dbg_data"}, bus.dbg_data, exp_dbg);
        checkVal({tag, " busy"}, {31'b0, bus.busy}, (clear_left > 0) ? 32'd1 : 32'd0);
    endtask

    // Reference behaviour: the bank is all-zero once reset, invisible for NREGS edges,
    // then a plain array with x0 pinned to zero.
    task automatic modelEdge(input stim_t s);
        logic [XLEN-1:0] wb;
        if (clear_left > 0) begin
            clear_left--;
            exp_rd1 = '0;
            exp_rd2 = '0;
            exp_dbg = '0;
        end else begin
            case (s.wbsel)
                2'd0:    wb = s.alu;
                2'd1:    wb = s.mem;
                2'd2:    wb = s.pc;
                default: wb = s.imm;
            endcase
            exp_dbg = (s.dbg == 0) ? '0 : model_regs[s.dbg];
            if (s.en) begin
                exp_rd1 = (s.rs1 == 0) ? '0 : model_regs[s.rs1];
                exp_rd2 = (s.rs2 == 0) ? '0 : model_regs[s.rs2];
`ifdef REGFILE_BYPASS_EN
                if (s.regwrite && s.rd != 0 && s.rd == s.rs1) exp_rd1 = wb;
                if (s.regwrite && s.rd != 0 && s.rd == s.rs2) exp_rd2 = wb;
`endif
            end
            if (s.en && s.regwrite && s.rd != 0)
                model_regs[s.rd] = wb;
        end
    endtask

    task automatic applyStimulus(input stim_t s, input string tag);
        bus.en         = s.en;
        bus.rs1        = s.rs1;
        bus.rs2        = s.rs2;
        bus.rd         = s.rd;
        bus.regwrite   = s.regwrite;
        bus.wbsel      = s.wbsel;
        bus.alu_result = s.alu;
        bus.mem_data   = s.mem;
        bus.pc_plus4   = s.pc;
        bus.imm        = s.imm;
        bus.dbg_addr   = s.dbg;
        @(posedge clk);
        modelEdge(s);
        #1;
        checkOutput(tag);
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.en = 1'b0; s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.regwrite = 1'b0; s.wbsel = 2'd0;
        s.alu = 32'h1111_1111; s.mem = 32'h2222_2222; s.pc = 32'h3333_3333; s.imm = 32'h4444_4444;
        s.dbg = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.en = ($urandom_range(0, 3) != 0);
        s.rs1 = ADDR_W'($urandom); s.rs2 = ADDR_W'($urandom); s.rd = ADDR_W'($urandom);
        s.regwrite = 1'($urandom); s.wbsel = 2'($urandom);
        s.alu = $urandom; s.mem = $urandom; s.pc = $urandom; s.imm = $urandom;
        s.dbg = ADDR_W'($urandom);
        return s;
    endfunction

    // Called #1 after an active edge; outputs must drop before the next edge.
    task automatic doReset(input int cycles, input string tag);
        rst = 1'b1;
        clear_left = NREGS;
        for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
        exp_rd1 = '0; exp_rd2 = '0; exp_dbg = '0;
        #1;
        checkOutput({tag, " async"});
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Hammers writes during the clear; they must all be ignored.
    task automatic countClear(input string tag);
        int cycles = 0;
        stim_t s;
        for (int k = 1; k <= 40 && cycles == 0; k++) begin
            s = randStim();
            s.en = 1'b1;
            s.regwrite = 1'b1;
            applyStimulus(s, {tag, " clearing"});
            if (!bus.busy) cycles = k;
        end
        checkVal({tag, " clear length"}, 32'(cycles), 32'(NREGS));
    endtask

    task automatic checkAllZero(input string tag);
        stim_t s;
        for (int i = 0; i < NREGS; i++) begin
            s = idleStim();
            s.en  = 1'b1;
            s.rs1 = ADDR_W'(i);
            s.rs2 = ADDR_W'(NREGS - 1 - i);
            s.dbg = ADDR_W'(i);
            applyStimulus(s, {tag, " zero scan"});
            checkVal({tag, " zero dbg"}, bus.dbg_data, 32'h0);
            checkVal({tag, " zero rd1"}, bus.readdata1, 32'h0);
        end
    endtask

    initial begin
        wvec_t wtab [4];
        stim_t s;

        wtab[0] = '{"wb alu x5", 5'd5, 2'd0, 32'h0000_1234, 32'h0000_1234};
        wtab[1] = '{"wb mem x6", 5'd6, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        wtab[2] = '{"wb pc x1",  5'd1, 2'd2, 32'h0000_0104, 32'h0000_0104};
        wtab[3] = '{"wb imm x7", 5'd7, 2'd3, 32'hABCD_E000, 32'hABCD_E000};

        s = idleStim();
        bus.en = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.regwrite = 1'b0;
        bus.wbsel = '0; bus.alu_result = '0; bus.mem_data = '0; bus.pc_plus4 = '0;
        bus.imm = '0; bus.dbg_addr = '0;
        rst = 1'b1;
        clear_left = NREGS;
        for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
        exp_rd1 = '0; exp_rd2 = '0; exp_dbg = '0;
        #2;
        checkOutput("power-on reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        countClear("initial");

        for (int i = 0; i < 4; i++) begin
            s = idleStim();
            s.en = 1'b1; s.regwrite = 1'b1; s.rd = wtab[i].rd; s.wbsel = wtab[i].wbsel;
            case (wtab[i].wbsel)
                2'd0:    s.alu = wtab[i].value;
                2'd1:    s.mem = wtab[i].value;
                2'd2:    s.pc  = wtab[i].value;
                default: s.imm = wtab[i].value;
            endcase
            applyStimulus(s, wtab[i].name);
        end
        for (int i = 0; i < 4; i++) begin
            s = idleStim();
            s.en = 1'b1; s.rs1 = wtab[i].rd;
            applyStimulus(s, wtab[i].name);
            checkVal(wtab[i].name, bus.readdata1, wtab[i].expect_val);
        end

        s = idleStim();
        s.en = 1'b1; s.regwrite = 1'b1; s.rd = 5'd0; s.alu = 32'hFFFF_FFFF;
        applyStimulus(s, "x0 write");
        s = idleStim();
        s.en = 1'b1; s.rs1 = 5'd0; s.dbg = 5'd0;
        applyStimulus(s, "x0 read");
        checkVal("x0 rd1", bus.readdata1, 32'h0);
        checkVal("x0 dbg", bus.dbg_data, 32'h0);

        s = idleStim();
        s.en = 1'b1; s.regwrite = 1'b1; s.rd = 5'd3; s.alu = 32'd7;
        applyStimulus(s, "hazard setup");
        s.rs1 = 5'd3; s.rs2 = 5'd3; s.alu = 32'd9;
        applyStimulus(s, "hazard edge");
`ifdef REGFILE_BYPASS_EN
        checkVal("hazard rd1", bus.readdata1, 32'd9);
        checkVal("hazard rd2", bus.readdata2, 32'd9);
`else
        checkVal("hazard rd1", bus.readdata1, 32'd7);
        checkVal("hazard rd2", bus.readdata2, 32'd7);
`endif
        s = idleStim();
        s.en = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd3;
        applyStimulus(s, "hazard after");
        checkVal("hazard after rd1", bus.readdata1, 32'd9);
        checkVal("hazard after rd2", bus.readdata2, 32'd9);

        s = idleStim();
        s.en = 1'b1; s.rs1 = 5'd5;
        applyStimulus(s, "hold load");
        for (int i = 0; i < 3; i++) begin
            s = idleStim();
            s.rs1 = ADDR_W'(6 + i);
            s.regwrite = 1'b1; s.rd = 5'd5; s.alu = 32'hBAD0_0000;
            applyStimulus(s, "hold");
            checkVal("hold rd1", bus.readdata1, 32'h0000_1234);
        end

        for (int i = 0; i < 400; i++)
            applyStimulus(randStim(), "random");

        doReset(2, "reset preloaded");
        countClear("preloaded");
        checkAllZero("preloaded");

        doReset(2, "reset before mid-clear");
        for (int i = 0; i < 10; i++)
            applyStimulus(randStim(), "partial clear");
        doReset(1, "reset mid-clear");
        countClear("mid-clear");
        checkAllZero("mid-clear");

        for (int i = 0; i < 30; i++) begin
            s = randStim();
            s.en = 1'b1;
            applyStimulus(s, "run writes");
        end
        doReset(2, "reset mid-run");
        countClear("mid-run");
        checkAllZero("mid-run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
